// File: rtl/score_arbiter.sv
// Round-robin arbiter that applies 2-digit BCD increments to a packed-BCD score,
// one digit per cycle, saturating at all-9s and committing the full result at once.
//
// state  | meaning
// IDLE   | waiting; services a pending clear first, otherwise grants a requester
// ADD    | adding addend into the work copy, digit idx per cycle, ripple carry
// COMMIT | publish work (or all-9s on final carry) to points
module score_arbiter #(
    parameter int NREQ   = 3,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [8*NREQ-1:0]     add_bcd,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   points,
    output logic                  points_vld,
    output logic                  sat
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, COMMIT} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    points_nx, work, work_nx, addend, addend_nx;
    logic [NREQ-1:0] ack_nx;
    logic            vld_nx, sat_nx, clr_pend, clr_pend_nx, carry, carry_nx;
    logic [PW-1:0]   rr_ptr, rr_ptr_nx, gnt_idx, cand;
    logic [IW-1:0]   idx, idx_nx;
    logic            gnt_found;
    logic [7:0]      add_sel;
    logic [3:0]      work_dig, add_dig;
    logic [4:0]      dsum;

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // First set request at or above the pointer, wrapping mod NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand = PW'((int'(rr_ptr) + j) % NREQ);
            if (!gnt_found && req[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        add_sel = add_bcd[8*gnt_idx +: 8];
    end

    always_comb begin
        work_dig = work[4*idx +: 4];
        add_dig  = addend[4*idx +: 4];
        dsum     = {1'b0, work_dig} + {1'b0, add_dig} + {4'b0, carry};
    end

    always_comb begin
        state_nx    = state;
        points_nx   = points;
        work_nx     = work;
        addend_nx   = addend;
        ack_nx      = '0;
        vld_nx      = 1'b0;
        sat_nx      = sat;
        clr_pend_nx = clr_pend;
        carry_nx    = carry;
        rr_ptr_nx   = rr_ptr;
        idx_nx      = idx;
        case (state)
            IDLE: begin
                if (clr || clr_pend) begin
                    points_nx   = '0;
                    sat_nx      = 1'b0;
                    vld_nx      = 1'b1;
                    clr_pend_nx = 1'b0;
                end else if (gnt_found) begin
                    addend_nx       = W'({clamp9(add_sel[7:4]), clamp9(add_sel[3:0])});
                    work_nx         = points;
                    ack_nx[gnt_idx] = 1'b1;
                    idx_nx          = '0;
                    carry_nx        = 1'b0;
                    state_nx        = ADD;
                    rr_ptr_nx       = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                end
            end
            ADD: begin
                clr_pend_nx           = clr_pend | clr;
                work_nx[4*idx +: 4]   = (dsum > 5'd9) ? 4'(dsum - 5'd10) : dsum[3:0];
                carry_nx              = (dsum > 5'd9);
                if (idx == IW'(DIGITS - 1)) state_nx = COMMIT;
                else                        idx_nx   = idx + 1'b1;
            end
            COMMIT: begin
                clr_pend_nx = clr_pend | clr;
                points_nx   = carry ? {DIGITS{4'h9}} : work;
                if (carry) sat_nx = 1'b1;
                vld_nx      = 1'b1;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            points     <= '0;
            work       <= '0;
            addend     <= '0;
            ack        <= '0;
            points_vld <= 1'b0;
            sat        <= 1'b0;
            clr_pend   <= 1'b0;
            carry      <= 1'b0;
            rr_ptr     <= '0;
            idx        <= '0;
        end else begin
            state      <= state_nx;
            points     <= points_nx;
            work       <= work_nx;
            addend     <= addend_nx;
            ack        <= ack_nx;
            points_vld <= vld_nx;
            sat        <= sat_nx;
            clr_pend   <= clr_pend_nx;
            carry      <= carry_nx;
            rr_ptr     <= rr_ptr_nx;
            idx        <= idx_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_score_arbiter.sv
// Scoreboard bench for score_arbiter: a 6-digit/3-source instance for the main
// scenarios and a 2-digit instance to reach saturation quickly.
module tb_score_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, clr, clr2;
    logic [2:0]  req, req2, ack, ack2;
    logic [23:0] add_bcd, add2, points;
    logic [7:0]  points2;
    logic        busy, busy2, points_vld, vld2, sat, sat2;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int overlap = 0;

    int          model_pts;
    logic        model_sat;
    int          model_ptr;
    logic [23:0] exp_q[$];

    score_arbiter #(.NREQ(3), .DIGITS(6)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req(req), .add_bcd(add_bcd),
        .ack(ack), .busy(busy), .points(points), .points_vld(points_vld), .sat(sat)
    );

    score_arbiter #(.NREQ(3), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clr(clr2), .req(req2), .add_bcd(add2),
        .ack(ack2), .busy(busy2), .points(points2), .points_vld(vld2), .sat(sat2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if ((ack !== 3'b000 && points_vld === 1'b1) ||
                              (ack2 !== 3'b000 && vld2 === 1'b1)) overlap++;

    function automatic int clampv(input logic [7:0] a);
        int hi, lo;
        hi = (a[7:4] > 4'd9) ? 9 : int'(a[7:4]);
        lo = (a[3:0] > 4'd9) ? 9 : int'(a[3:0]);
        return hi * 10 + lo;
    endfunction

    function automatic logic [23:0] int2bcd(input int v);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0; clr = 1'b0; clr2 = 1'b0;
        req = '0; req2 = '0; add_bcd = '0; add2 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_pts = 0; model_sat = 1'b0; model_ptr = 0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Waits for a grant with whatever req is held, checks it against the RR model,
    // drops the granted bit, then checks ack width, commit latency and the result.
    task automatic serve_one(output int gsrc, output int ack_cyc);
        int n, exp_src;
        logic [23:0] exp_pts;
        n = 0;
        while (ack === 3'b000 && n < 20) begin @(negedge clk); n++; end
        ack_cyc = cyc;
        exp_src = 0;
        for (int j = 2; j >= 0; j--) if (req[(model_ptr + j) % 3]) exp_src = (model_ptr + j) % 3;
        vectors++;
        if (ack !== (3'b001 << exp_src)) begin
            errors++; $display("FAIL grant: ack=%b required %b", ack, 3'b001 << exp_src);
        end
        gsrc = exp_src;
        model_ptr = (exp_src + 1) % 3;
        model_pts = model_pts + clampv(add_bcd[8*exp_src +: 8]);
        if (model_pts > 999999) begin model_pts = 999999; model_sat = 1'b1; end
        exp_q.push_back(int2bcd(model_pts));
        req[exp_src] = 1'b0;
        @(negedge clk); n = 1;
        vectors++;
        if (ack !== 3'b000) begin errors++; $display("FAIL ack_pulse: ack=%b required 000", ack); end
        while (points_vld !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n !== 7) begin errors++; $display("FAIL latency: %0d cycles required 7", n); end
        exp_pts = exp_q.pop_front();
        vectors++;
        if (points !== exp_pts || sat !== model_sat) begin
            errors++; $display("FAIL points: %h sat=%b required %h sat=%b", points, sat, exp_pts, model_sat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; clr2 = 1'b0; req = '0; req2 = '0; add_bcd = '0; add2 = '0;
        #2;
        vectors++;
        if ({points, ack, points_vld, sat, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs: points=%h ack=%b vld=%b sat=%b busy=%b required all 0",
                               points, ack, points_vld, sat, busy);
        end
        apply_reset();
    endtask

    task automatic test_single_add();
        int g, c;
        apply_reset();
        add_bcd[7:0] = 8'h25; req = 3'b001;
        serve_one(g, c);
    endtask

    task automatic test_carry_ripple();
        int g, c;
        apply_reset();
        add_bcd[7:0] = 8'h99; req = 3'b001;
        serve_one(g, c);
        @(negedge clk);
        add_bcd[7:0] = 8'h01; req = 3'b001;
        serve_one(g, c);
    endtask

    task automatic test_back_to_back();
        int g, c, prev_c;
        int exp_g[4] = '{0, 1, 0, 1};
        apply_reset();
        add_bcd = {8'h00, 8'h01, 8'h01};
        req = 3'b011;
        prev_c = 0;
        for (int k = 0; k < 4; k++) begin
            serve_one(g, c);
            vectors++;
            if (g !== exp_g[k]) begin errors++; $display("FAIL rr_order: grant %0d src=%0d required %0d", k, g, exp_g[k]); end
            if (k > 0) begin
                vectors++;
                if (c - prev_c !== 8) begin errors++; $display("FAIL throughput: %0d cycles required 8", c - prev_c); end
            end
            prev_c = c;
            if (k < 2) req[g] = 1'b1;
        end
        req = '0;
        vectors++;
        if (points !== 24'h000004) begin errors++; $display("FAIL rr_total: %h required 000004", points); end
    endtask

    task automatic test_saturate();
        logic [7:0] vals[3] = '{8'h60, 8'h60, 8'h01};
        int m2, n;
        logic s2;
        apply_reset();
        m2 = 0; s2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            add2[7:0] = vals[k]; req2 = 3'b001;
            n = 0;
            while (ack2 === 3'b000 && n < 20) begin @(negedge clk); n++; end
            req2 = '0;
            m2 = m2 + clampv(vals[k]);
            if (m2 > 99) begin m2 = 99; s2 = 1'b1; end
            n = 0;
            while (vld2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            vectors++;
            if (n !== 3 || points2 !== int2bcd(m2)[7:0] || sat2 !== s2) begin
                errors++; $display("FAIL sat_add%0d: %h sat=%b lat=%0d required %h sat=%b lat=3",
                                   k, points2, sat2, n, int2bcd(m2)[7:0], s2);
            end
        end
        @(negedge clk);
        clr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0;
        vectors++;
        if (points2 !== 8'h00 || sat2 !== 1'b0 || vld2 !== 1'b1 || ack2 !== 3'b000) begin
            errors++; $display("FAIL sat_clear: %h sat=%b vld=%b ack=%b required 00 0 1 000", points2, sat2, vld2, ack2);
        end
    endtask

    task automatic test_clamp_and_clear_while_busy();
        int n;
        apply_reset();
        add_bcd[7:0] = 8'hAF; req = 3'b001;
        n = 0;
        while (ack === 3'b000 && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (ack !== 3'b001) begin errors++; $display("FAIL clamp_grant: ack=%b required 001", ack); end
        req = '0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n = 0;
        while (points_vld !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (points !== 24'h000099) begin errors++; $display("FAIL clamp_commit: %h required 000099", points); end
        @(negedge clk);
        vectors++;
        if (points !== 24'h000000 || points_vld !== 1'b1 || ack !== 3'b000) begin
            errors++; $display("FAIL pending_clear: %h vld=%b ack=%b required 000000 1 000", points, points_vld, ack);
        end
        @(negedge clk);
        vectors++;
        if (points_vld !== 1'b0) begin errors++; $display("FAIL clear_pulse: vld=%b required 0", points_vld); end
        model_pts = 0;
    endtask

    task automatic test_reset_mid_add();
        int g, c, n, seen;
        apply_reset();
        add_bcd[7:0] = 8'h11; req = 3'b001;
        serve_one(g, c);
        @(negedge clk);
        add_bcd[7:0] = 8'h22; req = 3'b001;
        n = 0;
        while (ack === 3'b000 && n < 20) begin @(negedge clk); n++; end
        req = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || points !== 24'h000011) begin
            errors++; $display("FAIL pre_reset: busy=%b points=%h required 1 000011", busy, points);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({points, ack, points_vld, sat, busy} !== '0) begin
            errors++; $display("FAIL async_reset: points=%h ack=%b vld=%b sat=%b busy=%b required all 0",
                               points, ack, points_vld, sat, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_pts = 0; model_ptr = 0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack !== 3'b000 || points_vld !== 1'b0) seen++;
        end
        vectors++;
        if (seen !== 0 || points !== 24'h0) begin
            errors++; $display("FAIL post_reset: %0d ack/vld cycles points=%h required 0 000000", seen, points);
        end
    endtask

    task automatic test_invariants();
        vectors++;
        if (overlap !== 0) begin errors++; $display("FAIL ack_vld_overlap: %0d cycles required 0", overlap); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_carry_ripple();
        test_back_to_back();
        test_saturate();
        test_clamp_and_clear_while_busy();
        test_reset_mid_add();
        test_invariants();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
